// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core and its receiver.
// Optional parity is enabled by defining UART_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned bit_ticks(input int unsigned clk_hz,
                                            input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_core_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, framing/break handling.
// Parity check is present only when UART_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_TICKS  = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o
);

  localparam int unsigned CW = $clog2(BIT_TICKS + 1);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_TICKS / 2);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  logic                 rx, tick;
  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 pbad_q, pbad_d;

  assign rx   = sync2_q;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pbad_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pbad_q  <= pbad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pbad_d  = pbad_q;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx) begin
          state_d = RX_START;
          cnt_d   = HALF;
        end
      end
      // A high line at any point before mid-start is a glitch, not a frame.
      RX_START: begin
        if (rx) begin
          state_d = RX_IDLE;
        end else if (tick) begin
          state_d = RX_DATA;
          cnt_d   = FULL;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST) begin
`ifdef UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          pbad_d  = rx ^ (^shift_q) ^ 1'(PARITY_ODD);
          cnt_d   = FULL;
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (tick) state_d = rx ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        if (rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    if (state_q == RX_STOP && tick) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      ferr_d  = !rx;
`ifdef UART_PARITY_EN
      perr_d  = pbad_q;
`else
      perr_d  = 1'b0;
`endif
    end
  end

`ifndef UART_PARITY_EN
  logic unused_parity_cfg;
  assign unused_parity_cfg = 1'(PARITY_ODD);
`endif

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with valid/ready fabric side; TX FSM here, RX in uart_rx.
// Define UART_PARITY_EN to add a parity bit after the data bits.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 ipClk,
  input  logic                 ipReset,
  input  logic [DATA_BITS-1:0] ipTxData,
  input  logic                 ipTxValid,
  output logic                 opTxReady,
  output logic                 opTx,
  input  logic                 ipRx,
  output logic [DATA_BITS-1:0] opRxData,
  output logic                 opRxValid,
  output logic                 opRxFrameErr,
  output logic                 opRxParityErr
);

  localparam int unsigned BIT_TICKS = bit_ticks(CLK_HZ, BAUD);
  localparam int unsigned CW = $clog2(BIT_TICKS + 1);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL      = CW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_tick, tx_accept;

  assign tx_tick   = (tx_cnt_q == '0);
  assign tx_accept = ipTxValid && opTxReady;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_accept) begin
          tx_state_d = TX_START;
          tx_cnt_d   = FULL;
          tx_bit_d   = '0;
          tx_shift_d = ipTxData;
`ifdef UART_PARITY_EN
          tx_par_d   = (^ipTxData) ^ 1'(PARITY_ODD);
`endif
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = FULL;
        end
      end
      // The bit counter is reused to count stop bits once data is out.
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d   = FULL;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + BW'(1);
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d   = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = FULL;
        end
      end
`endif
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_bit_q == LAST_STOP) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + BW'(1);
            tx_cnt_d = FULL;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Ready is masked during reset so it rises on the first released cycle.
  always_comb begin
    opTx      = 1'b1;
    opTxReady = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:   opTxReady = !ipReset;
      TX_START:  opTx      = 1'b0;
      TX_DATA:   opTx      = tx_shift_q[0];
      TX_PARITY: opTx      = tx_par_q;
      TX_STOP:   opTx      = 1'b1;
      default:   opTx      = 1'b1;
    endcase
  end

  uart_rx #(
    .BIT_TICKS (BIT_TICKS),
    .DATA_BITS (DATA_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) u_rx (
    .clk_i       (ipClk),
    .rst_i       (ipReset),
    .rx_i        (ipRx),
    .data_o      (opRxData),
    .valid_o     (opRxValid),
    .frame_err_o (opRxFrameErr),
    .parity_err_o(opRxParityErr)
  );

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: per-cycle frame model plus RX scoreboard.
// Built with UART_PARITY_EN it runs the 7-bit even-parity variant.
module tb_uart_core;

  localparam int BT = 434;
`ifdef UART_PARITY_EN
  localparam int DB = 7;
  localparam int PB = 1;
`else
  localparam int DB = 8;
  localparam int PB = 0;
`endif
  localparam int SB = 1;
  localparam int FB = 1 + DB + PB + SB;
  localparam int FC = FB * BT;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          fe;
    logic          pe;
  } rx_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DB-1:0] ipTxData;
  logic          ipTxValid;
  logic          opTxReady, opTx;
  logic          rx_drv, loop_en, rx_line;
  logic [DB-1:0] opRxData;
  logic          opRxValid, opRxFrameErr, opRxParityErr;

  int            n_cmp = 0;
  int            n_bad = 0;
  rx_exp_t       exp_q[$];
  rx_exp_t       e;
  int            m_pos;
  logic [FB-1:0] m_frame;
  logic [DB-1:0] last_rx;
  logic          rst_edge;
  int            fe_pulses = 0;
  int            pe_pulses = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? opTx : rx_drv;

  uart_core #(
    .CLK_HZ    (50_000_000),
    .BAUD      (115_200),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(0)
  ) dut (
    .ipClk        (clk),
    .ipReset      (rst),
    .ipTxData     (ipTxData),
    .ipTxValid    (ipTxValid),
    .opTxReady    (opTxReady),
    .opTx         (opTx),
    .ipRx         (rx_line),
    .opRxData     (opRxData),
    .opRxValid    (opRxValid),
    .opRxFrameErr (opRxFrameErr),
    .opRxParityErr(opRxParityErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line levels in transmit order: start, data LSB first, [parity], stop(s).
  function automatic logic [FB-1:0] frame_of(input logic [DB-1:0] d, input logic stop,
                                             input logic flip_par);
    logic [FB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
    f[1+DB] = (^d) ^ flip_par;
`else
    if (flip_par) f[0] = 1'b0;
`endif
    f[FB-SB] = stop;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [DB-1:0] d);
    int w;
    w         = 0;
    ipTxData  = d;
    ipTxValid = 1'b1;
    while (opTxReady !== 1'b1 && w < 2 * FC) begin
      tick(1);
      w++;
    end
    check("tx_accept_wait", 32'(w < 2 * FC), 32'd1);
    tick(1);
    ipTxValid = 1'b0;
  endtask

  task automatic drive_frame(input logic [FB-1:0] f);
    for (int i = 0; i < FB; i++) begin
      rx_drv = f[i];
      tick(BT);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2 * FC) begin
      tick(1);
      w++;
    end
    check("rx_drain", 32'(exp_q.size()), 32'd0);
    tick(4);
  endtask

  task automatic push(input logic [DB-1:0] d, input logic fe, input logic pe);
    rx_exp_t x;
    x.d  = d;
    x.fe = fe;
    x.pe = pe;
    exp_q.push_back(x);
  endtask

  initial begin
    logic [FB-1:0] cap;
    logic [FB-1:0] t2_line;
    logic [DB-1:0] t2_word;
    int            lowcnt;
    logic [7:0]    words [3];

    rst       = 1'b1;
    ipTxData  = '0;
    ipTxValid = 1'b0;
    rx_drv    = 1'b1;
    loop_en   = 1'b0;
    m_pos     = -1;
    m_frame   = '1;
    last_rx   = '0;
    rst_edge  = 1'b1;

    fork
      forever begin
        @(posedge clk);
        rst_edge = rst;
        if (rst) begin
          m_pos   = -1;
          last_rx = '0;
        end else if (m_pos < 0) begin
          if (ipTxValid) begin
            m_frame = frame_of(ipTxData, 1'b1, 1'b0);
            m_pos   = 0;
          end
        end else if (m_pos == FC - 1) begin
          m_pos = -1;
        end else begin
          m_pos++;
        end
        @(negedge clk);
        check("tx_line", 32'(opTx), 32'((m_pos < 0) ? 1'b1 : m_frame[m_pos / BT]));
        check("tx_ready", 32'(opTxReady), 32'(m_pos < 0 && !rst));
        if (rst_edge) begin
          check("rst_rx_valid", 32'(opRxValid), 32'd0);
          check("rst_rx_ferr", 32'(opRxFrameErr), 32'd0);
          check("rst_rx_perr", 32'(opRxParityErr), 32'd0);
        end
        if (opRxValid === 1'b1) begin
          if (opRxFrameErr === 1'b1) fe_pulses++;
          if (opRxParityErr === 1'b1) pe_pulses++;
          if (exp_q.size() == 0) begin
            check("rx_unexpected_valid", 32'(opRxValid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", 32'(opRxData), 32'(e.d));
            check("rx_frame_err", 32'(opRxFrameErr), 32'(e.fe));
            check("rx_parity_err", 32'(opRxParityErr), 32'(e.pe));
            last_rx = e.d;
          end
        end else begin
          check("rx_data_hold", 32'(opRxData), 32'(last_rx));
        end
      end
    join_none

    tick(3);
    rst = 1'b0;

    // Reset in the middle of a frame.
    send_tx(DB'(8'hC3));
    tick(1000);
    rst = 1'b1;
    tick(1);
    check("rst_midframe_tx", 32'(opTx), 32'd1);
    check("rst_midframe_ready", 32'(opTxReady), 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    check("ready_after_release", 32'(opTxReady), 32'd1);
    tick(2);

`ifdef UART_PARITY_EN
    t2_word = 7'h41;
    t2_line = 10'b1010000010;
`else
    t2_word = 8'hA5;
    t2_line = 10'b1101001010;
`endif
    send_tx(t2_word);
    cap    = '0;
    lowcnt = 0;
    for (int c = 0; c < FC + 5; c++) begin
      if ((c % BT) == (BT / 2) && (c / BT) < FB) cap[c / BT] = opTx;
      if (opTxReady !== 1'b1) lowcnt++;
      tick(1);
    end
    check("tx_line_pattern", 32'(cap), 32'(t2_line));
    check("tx_busy_cycles", 32'(lowcnt), 32'd4340);

    // Loopback, back-to-back words.
    loop_en  = 1'b1;
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h55;
    for (int i = 0; i < 3; i++) push(DB'(words[i]), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_tx(DB'(words[i]));
    drain();
    check("loop_last_word", 32'(opRxData), 32'(DB'(8'h55)));
    tick(BT);
    loop_en = 1'b0;
    tick(10);

    // Short low glitch, then a clean frame.
    rx_drv = 1'b0;
    tick(200);
    rx_drv = 1'b1;
    tick(2 * BT);
    push(DB'(8'h3C), 1'b0, 1'b0);
    drive_frame(frame_of(DB'(8'h3C), 1'b1, 1'b0));
    drain();
    check("glitch_then_3c", 32'(opRxData), 32'h3C);

    // Stop bit low, line held low, then recovery.
    push(DB'(8'h81), 1'b1, 1'b0);
    drive_frame(frame_of(DB'(8'h81), 1'b0, 1'b0));
    rx_drv = 1'b0;
    tick(3 * FC);
    rx_drv = 1'b1;
    tick(BT);
    push(DB'(8'h81), 1'b0, 1'b0);
    drive_frame(frame_of(DB'(8'h81), 1'b1, 1'b0));
    drain();
    check("break_one_err_word", 32'(fe_pulses), 32'd1);

`ifdef UART_PARITY_EN
    push(7'h41, 1'b0, 1'b1);
    drive_frame(frame_of(7'h41, 1'b1, 1'b1));
    drain();
    check("parity_err_pulses", 32'(pe_pulses), 32'd1);
`else
    check("parity_err_pulses", 32'(pe_pulses), 32'd0);
`endif

    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
